// File: rtl/sync_event_arbiter.sv
// Collects rising edges from synchronised request lines and hands them one at a
// time, round-robin, to a single valid/ready event consumer.
module sync_event_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] sync_in,
    input  logic [NUM_SRC-1:0] en_mask,
    input  logic [NUM_SRC-1:0] overrun_clr,
    output logic               evt_valid,
    output logic [IDX_W-1:0]   evt_idx,
    input  logic               evt_ready,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);

    // Handshake: an event transfers on any clk edge where evt_valid && evt_ready;
    // while evt_ready is low, evt_valid and evt_idx hold their values.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [0:0]         state;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] avail;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] overrun_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_after;
    logic [IDX_W-1:0]   sel_ptr;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               transfer;
    logic               take;
    int                 idx;

    assign rise      = sync_in & ~prev & en_mask;
    assign avail     = pending & en_mask;
    assign transfer  = (state == S_OFFER) && evt_ready;
    assign ptr_after = (evt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : evt_idx + 1'b1;
    // On a transfer the search already starts after the source just delivered.
    assign sel_ptr   = (state == S_OFFER) ? ptr_after : rr_ptr;
    assign take      = found && ((state == S_IDLE) || transfer);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(sel_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            cand = IDX_W'(idx);
            if (!found && avail[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (take) grant[sel] = 1'b1;
    end

    // A rise in the grant cycle re-arms the source rather than counting as an overrun.
    assign pending_nxt = en_mask & ((pending & ~grant) | rise);
    assign overrun_nxt = (rise & pending & ~grant) | (overrun & ~overrun_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            prev      <= sync_in;
            pending   <= '0;
            overrun   <= '0;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
        end else begin
            prev    <= sync_in;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        evt_idx   <= sel;
                        evt_valid <= 1'b1;
                        state     <= S_OFFER;
                    end
                end
                default: begin
                    if (evt_ready) begin
                        rr_ptr <= ptr_after;
                        if (found) begin
                            evt_idx <= sel;
                        end else begin
                            evt_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Bench for sync_event_arbiter: directed scenarios plus random traffic, scored
// against a per-source reference model and an expected-event queue.
module tb_sync_event_arbiter;

    localparam int NUM_SRC = 4;
    localparam int IDX_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] sync_in;
    logic [NUM_SRC-1:0] en_mask;
    logic [NUM_SRC-1:0] overrun_clr;
    logic               evt_valid;
    logic [IDX_W-1:0]   evt_idx;
    logic               evt_ready;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [IDX_W-1:0] exp_q[$];

    // Inputs as seen by the DUT at the coming clock edge.
    logic [NUM_SRC-1:0] a_s, a_en, a_clr;
    logic               a_rdy, a_rst;

    // Reference model state.
    bit m_prev[NUM_SRC];
    bit m_pend[NUM_SRC];
    bit m_ovr[NUM_SRC];
    int m_ptr;
    bit m_off_v;
    int m_off_idx;

    sync_event_arbiter #(.NUM_SRC(NUM_SRC)) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_in     (sync_in),
        .en_mask     (en_mask),
        .overrun_clr (overrun_clr),
        .evt_valid   (evt_valid),
        .evt_idx     (evt_idx),
        .evt_ready   (evt_ready),
        .pending     (pending),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic [NUM_SRC-1:0] s, input logic [NUM_SRC-1:0] en,
                              input logic [NUM_SRC-1:0] clr, input logic rdy, input logic r);
        bit rise[NUM_SRC];
        int granted;
        int ptr;
        bit can;
        if (r) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                m_prev[i] = s[i];
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end
            m_ptr = 0; m_off_v = 1'b0; m_off_idx = 0;
            return;
        end
        granted = -1;
        can     = 1'b0;
        ptr     = m_ptr;
        for (int i = 0; i < NUM_SRC; i++) rise[i] = s[i] && !m_prev[i] && en[i];
        if (!m_off_v) begin
            can = 1'b1;
        end else if (rdy) begin
            m_ptr   = (m_off_idx + 1) % NUM_SRC;
            ptr     = m_ptr;
            m_off_v = 1'b0;
            can     = 1'b1;
        end
        if (can) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                int j;
                j = (ptr + k) % NUM_SRC;
                if (granted < 0 && m_pend[j] && en[j]) granted = j;
            end
        end
        if (granted >= 0) begin
            m_off_v   = 1'b1;
            m_off_idx = granted;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rise[i] && m_pend[i] && i != granted) m_ovr[i] = 1'b1;
            else if (clr[i]) m_ovr[i] = 1'b0;
            if (!en[i]) m_pend[i] = 1'b0;
            else if (rise[i]) m_pend[i] = 1'b1;
            else if (i == granted) m_pend[i] = 1'b0;
            m_prev[i] = s[i];
        end
    endtask

    // One clock: advance the model over the edge just taken, compare, drive new inputs.
    task automatic drive(input logic [NUM_SRC-1:0] s, input logic [NUM_SRC-1:0] en,
                         input logic [NUM_SRC-1:0] clr, input logic rdy, input logic r);
        logic [NUM_SRC-1:0] mp, mo;
        @(posedge clk);
        #1;
        model_step(a_s, a_en, a_clr, a_rdy, a_rst);
        for (int i = 0; i < NUM_SRC; i++) begin
            mp[i] = m_pend[i];
            mo[i] = m_ovr[i];
        end
        check("evt_valid", {31'b0, evt_valid}, {31'b0, m_off_v});
        if (m_off_v || a_rst) check("evt_idx", {30'b0, evt_idx}, m_off_idx);
        check("pending", {28'b0, pending}, {28'b0, mp});
        check("overrun", {28'b0, overrun}, {28'b0, mo});
        sync_in = s; en_mask = en; overrun_clr = clr; evt_ready = rdy; rst = r;
        a_s = s; a_en = en; a_clr = clr; a_rdy = rdy; a_rst = r;
        if (m_off_v && rdy && !r) exp_q.push_back(IDX_W'(m_off_idx));
    endtask

    task automatic hold(input int n, input logic [NUM_SRC-1:0] s, input logic rdy);
        for (int i = 0; i < n; i++) drive(s, 4'hF, 4'h0, rdy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (evt_valid === 1'b1 && evt_ready === 1'b1 && rst === 1'b0) begin
            logic [IDX_W-1:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_transfer at %0t: got idx %0d expected no event", $time, evt_idx);
            end else begin
                e = exp_q.pop_front();
                if (evt_idx !== e) begin
                    n_err++;
                    $display("FAIL evt_transfer at %0t: got idx %0d expected %0d", $time, evt_idx, e);
                end
            end
        end
    end

    initial begin
        logic [NUM_SRC-1:0] s, en, clr;
        logic rdy, r;
        sync_in = 4'b0010; en_mask = 4'hF; overrun_clr = 4'h0; evt_ready = 1'b1; rst = 1'b1;
        a_s = sync_in; a_en = en_mask; a_clr = overrun_clr; a_rdy = evt_ready; a_rst = rst;

        // Line already high through reset release: no event.
        for (int i = 0; i < 3; i++) drive(4'b0010, 4'hF, 4'h0, 1'b1, 1'b1);
        hold(6, 4'b0010, 1'b1);
        hold(2, 4'b0000, 1'b1);
        // Single edge on source 2.
        hold(4, 4'b0100, 1'b1);
        hold(2, 4'b0000, 1'b1);
        // Simultaneous rises, then a second batch checking the pointer.
        hold(5, 4'b1011, 1'b1);
        hold(2, 4'b0000, 1'b1);
        hold(4, 4'b1001, 1'b1);
        hold(2, 4'b0000, 1'b1);
        // Backpressure with a second source arriving.
        hold(2, 4'b0010, 1'b0);
        hold(5, 4'b0011, 1'b0);
        hold(4, 4'b0011, 1'b1);
        hold(2, 4'b0000, 1'b1);
        // Overrun: blocked offer, source 3 rises twice.
        hold(2, 4'b0010, 1'b0);
        hold(2, 4'b1010, 1'b0);
        hold(1, 4'b0010, 1'b0);
        hold(3, 4'b1010, 1'b0);
        drive(4'b1010, 4'hF, 4'b1000, 1'b0, 1'b0);
        hold(2, 4'b1010, 1'b0);
        hold(1, 4'b0010, 1'b0);
        drive(4'b1010, 4'hF, 4'b1000, 1'b0, 1'b0);
        hold(2, 4'b1010, 1'b0);
        hold(4, 4'b0000, 1'b1);
        // Masking: edge on disabled source, then a pending source disabled.
        for (int i = 0; i < 3; i++) drive(4'b0100, 4'b1011, 4'h0, 1'b1, 1'b0);
        hold(2, 4'b0000, 1'b1);
        hold(2, 4'b0001, 1'b0);
        drive(4'b0011, 4'hF, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(4'b0011, 4'b1101, 4'h0, 1'b0, 1'b0);
        hold(3, 4'b0000, 1'b1);
        // Reset during an offer.
        hold(3, 4'b0100, 1'b0);
        drive(4'b0100, 4'hF, 4'h0, 1'b1, 1'b1);
        hold(3, 4'b0100, 1'b1);
        hold(2, 4'b0000, 1'b1);

        s = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_SRC; i++)
                if ($urandom_range(0, 9) < 3) s[i] = ~s[i];
            en  = ($urandom_range(0, 9) == 0) ? NUM_SRC'($urandom) : 4'hF;
            clr = 4'h0;
            for (int i = 0; i < NUM_SRC; i++) clr[i] = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 199) == 0);
            drive(s, en, clr, rdy, r);
        end

        hold(8, 4'b0000, 1'b1);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
